// File: rtl/rggen_rtl_pkg.sv
// Shared rggen register-bus types: access/status encodings, access bit
// positions, initiator FSM states and the timeout counter width helper.
// No ports; imported by the initiator and its timer.
package rggen_rtl_pkg;

   // Bit 0 of an access selects data direction (0 = read), bit 1 marks
   // whether the access expects a response (0 = posted).
   localparam int RGGEN_ACCESS_DATA_BIT       = 0;
   localparam int RGGEN_ACCESS_NON_POSTED_BIT = 1;

   typedef enum logic [1:0] {
      RGGEN_POSTED_WRITE = 2'b01,
      RGGEN_READ         = 2'b10,
      RGGEN_WRITE        = 2'b11
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RSP  = 2'b10
   } rggen_initiator_state;

   // Counter width able to hold 0..timeout, never narrower than one bit.
   function automatic int rggen_timer_width(int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rggen_bus_timer.sv
// Bus wait timer: counts enabled cycles, flags expiry on the TIMEOUT-th one.
// Latency: o_expire is combinational in the cycle the count would reach TIMEOUT.
// Backpressure: none; i_clear dominates, TIMEOUT=0 ties o_expire low.
// Ports: i_clk/i_rst_n clock and async reset, i_clear zeroes the count,
//        i_enable counts this cycle, o_expire timeout reached this cycle.
module rggen_bus_timer
   import rggen_rtl_pkg::*;
#(
   parameter int TIMEOUT = 0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   if (TIMEOUT == 0) begin : g_no_timer
      logic unused_inputs;
      assign unused_inputs = ^{i_clk, i_rst_n, i_clear, i_enable};
      assign o_expire      = 1'b0;
   end else begin : g_timer
      localparam int W = rggen_timer_width(TIMEOUT);

      logic [W-1:0] count_q;
      logic [W-1:0] count_d;

      // The cycle holding count TIMEOUT-1 is the TIMEOUT-th waiting cycle.
      assign o_expire = i_enable && (count_q == W'(TIMEOUT - 1));

      always_comb begin
         count_d = count_q;
         if (i_clear) begin
            count_d = '0;
         end else if (i_enable && !o_expire) begin
            count_d = count_q + 1'b1;
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            count_q <= '0;
         end else begin
            count_q <= count_d;
         end
      end
   end

endmodule

// File: rtl/rggen_bus_initiator.sv
// Register-bus initiator: one command -> one bus transaction -> one response.
// Latency: bus request the cycle after accept, response the cycle after bus ready.
// Backpressure: o_cmd_ready only in IDLE; response held until i_rsp_ready.
// Ports: i_cmd_* host command channel, o_rsp_*/i_rsp_ready response channel,
//        o_bus_*/i_bus_* register-bus request and completion.
module rggen_bus_initiator
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int BUS_WIDTH     = 32,
   parameter int TIMEOUT       = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic [1:0]               i_cmd_access,
   input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
   input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [1:0]               o_rsp_status,
   output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
   output logic                     o_bus_valid,
   output logic [1:0]               o_bus_access,
   output logic [ADDRESS_WIDTH-1:0] o_bus_address,
   output logic [BUS_WIDTH-1:0]     o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
   input  logic                     i_bus_ready,
   input  logic [1:0]               i_bus_status,
   input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

   rggen_initiator_state state_q, state_d;

   logic [1:0]               access_q,  access_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic [BUS_WIDTH-1:0]     wdata_q,   wdata_d;
   logic [BUS_WIDTH/8-1:0]   strobe_q,  strobe_d;
   logic [1:0]               status_q,  status_d;
   logic [BUS_WIDTH-1:0]     rdata_q,   rdata_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expire;

   rggen_bus_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (timer_clear),
      .i_enable (timer_enable),
      .o_expire (timer_expire)
   );

   always_comb begin
      state_d      = state_q;
      access_d     = access_q;
      address_d    = address_q;
      wdata_d      = wdata_q;
      strobe_d     = strobe_q;
      status_d     = status_q;
      rdata_d      = rdata_q;
      o_cmd_ready  = 1'b0;
      o_bus_valid  = 1'b0;
      o_rsp_valid  = 1'b0;
      // Held clear outside BUS so every entry to BUS starts from zero.
      timer_clear  = 1'b1;
      timer_enable = 1'b0;

      case (state_q)
         IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               access_d  = i_cmd_access;
               address_d = i_cmd_address;
               wdata_d   = i_cmd_write_data;
               strobe_d  = i_cmd_strobe;
               if (i_cmd_access == 2'b00) begin
                  // Illegal access: answer with an error, never touch the bus.
                  status_d = RGGEN_SLAVE_ERROR;
                  rdata_d  = '0;
                  state_d  = RSP;
               end else begin
                  state_d  = BUS;
               end
            end
         end
         BUS: begin
            o_bus_valid  = 1'b1;
            timer_clear  = 1'b0;
            timer_enable = !i_bus_ready;
            // Ready is checked first so a completion in the expiry cycle wins.
            if (i_bus_ready) begin
               status_d = i_bus_status;
               rdata_d  = access_q[RGGEN_ACCESS_DATA_BIT] ? '0 : i_bus_read_data;
               state_d  = access_q[RGGEN_ACCESS_NON_POSTED_BIT] ? RSP : IDLE;
            end else if (timer_expire) begin
               status_d = RGGEN_SLAVE_ERROR;
               rdata_d  = '0;
               state_d  = access_q[RGGEN_ACCESS_NON_POSTED_BIT] ? RSP : IDLE;
            end
         end
         RSP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         access_q  <= '0;
         address_q <= '0;
         wdata_q   <= '0;
         strobe_q  <= '0;
         status_q  <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         access_q  <= access_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
         strobe_q  <= strobe_d;
         status_q  <= status_d;
         rdata_q   <= rdata_d;
      end
   end

   assign o_bus_access     = access_q;
   assign o_bus_address    = address_q;
   assign o_bus_write_data = wdata_q;
   assign o_bus_strobe     = strobe_q;
   assign o_rsp_status     = status_q;
   assign o_rsp_read_data  = rdata_q;

endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Bench for rggen_bus_initiator (TIMEOUT=4): directed table, random
// transactions against a transaction-level model, and a mid-bus reset.
module tb_rggen_bus_initiator;

   localparam int AW = 16;
   localparam int BW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_access;
   logic [AW-1:0] cmd_address;
   logic [BW-1:0] cmd_wdata;
   logic [3:0]    cmd_strobe;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_status;
   logic [BW-1:0] rsp_rdata;
   logic          bus_valid;
   logic [1:0]    bus_access;
   logic [AW-1:0] bus_address;
   logic [BW-1:0] bus_wdata;
   logic [3:0]    bus_strobe;
   logic          bus_ready;
   logic [1:0]    bus_status;
   logic [BW-1:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rggen_bus_initiator #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW),
      .TIMEOUT       (TO)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_cmd_valid      (cmd_valid),
      .o_cmd_ready      (cmd_ready),
      .i_cmd_access     (cmd_access),
      .i_cmd_address    (cmd_address),
      .i_cmd_write_data (cmd_wdata),
      .i_cmd_strobe     (cmd_strobe),
      .o_rsp_valid      (rsp_valid),
      .i_rsp_ready      (rsp_ready),
      .o_rsp_status     (rsp_status),
      .o_rsp_read_data  (rsp_rdata),
      .o_bus_valid      (bus_valid),
      .o_bus_access     (bus_access),
      .o_bus_address    (bus_address),
      .o_bus_write_data (bus_wdata),
      .o_bus_strobe     (bus_strobe),
      .i_bus_ready      (bus_ready),
      .i_bus_status     (bus_status),
      .i_bus_read_data  (bus_rdata)
   );

   // Stimulus: command, cycle k of the bus request in which the target
   // answers (k > TO means never), target answer, response hold cycles.
   typedef struct {
      logic [1:0]    acc;
      logic [AW-1:0] addr;
      logic [BW-1:0] wd;
      logic [3:0]    strb;
      int            k;
      logic [1:0]    bst;
      logic [BW-1:0] rd;
      int            hold;
   } vec_t;

   // Expected outcome: response present, cycles o_bus_valid is high,
   // response status/data, cycle after accept at which o_cmd_ready returns.
   typedef struct {
      bit            rsp;
      int            bus_cycles;
      logic [1:0]    st;
      logic [BW-1:0] data;
      int            idle_at;
   } exp_t;

   typedef struct {
      vec_t v;
      exp_t e;
   } rec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic vec_t mkv(input logic [1:0] acc, input logic [AW-1:0] addr,
                                input logic [BW-1:0] wd, input logic [3:0] strb,
                                input int k, input logic [1:0] bst,
                                input logic [BW-1:0] rd, input int hold);
      vec_t v;
      v.acc = acc; v.addr = addr; v.wd = wd; v.strb = strb;
      v.k = k; v.bst = bst; v.rd = rd; v.hold = hold;
      return v;
   endfunction

   function automatic exp_t mke(input bit rsp, input int bus_cycles, input logic [1:0] st,
                                input logic [BW-1:0] data, input int idle_at);
      exp_t e;
      e.rsp = rsp; e.bus_cycles = bus_cycles; e.st = st; e.data = data; e.idle_at = idle_at;
      return e;
   endfunction

   // Transaction-level reference: what the host and the bus should observe.
   function automatic exp_t model(input vec_t v);
      exp_t e;
      e.rsp = (v.acc != 2'b01);
      if (v.acc == 2'b00) begin
         e.bus_cycles = 0;  e.st = 2'b10;  e.data = '0;
      end else if (v.k > TO) begin
         e.bus_cycles = TO; e.st = 2'b10;  e.data = '0;
      end else begin
         e.bus_cycles = v.k; e.st = v.bst;
         e.data = (v.acc == 2'b10) ? v.rd : '0;
      end
      e.idle_at = e.bus_cycles + (e.rsp ? v.hold + 1 : 0) + 1;
      return e;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with it idle.
   task automatic run_txn(input vec_t v, input exp_t e, input string tag);
      int         bus_cnt = 0;
      int         rsp_cnt = 0;
      int         it      = 0;
      int         idle_at = -1;
      bit         bus_bad = 0;
      bit         rsp_bad = 0;
      bit         overlap = 0;
      logic [1:0]    st_seen = '0;
      logic [BW-1:0] d_seen  = '0;
      cmd_valid = 1'b1; cmd_access = v.acc; cmd_address = v.addr;
      cmd_wdata = v.wd; cmd_strobe = v.strb;
      chk($sformatf("%s.cmd_ready", tag), cmd_ready, 1);
      while (idle_at < 0 && it < 60) begin
         @(negedge clk);
         it++;
         cmd_valid = 1'b0; bus_ready = 1'b0; rsp_ready = 1'b0;
         bus_status = '0;  bus_rdata = '0;
         if ((cmd_ready && (bus_valid || rsp_valid)) || (bus_valid && rsp_valid))
            overlap = 1;
         if (cmd_ready) begin
            idle_at = it;
         end else begin
            if (bus_valid) begin
               bus_cnt++;
               if (bus_access !== v.acc || bus_address !== v.addr ||
                   bus_wdata !== v.wd || bus_strobe !== v.strb)
                  bus_bad = 1;
               if (bus_cnt == v.k) begin
                  bus_ready = 1'b1; bus_status = v.bst; bus_rdata = v.rd;
               end
            end
            if (rsp_valid) begin
               rsp_cnt++;
               if (rsp_cnt == 1) begin
                  st_seen = rsp_status; d_seen = rsp_rdata;
               end else if (rsp_status !== st_seen || rsp_rdata !== d_seen) begin
                  rsp_bad = 1;
               end
               if (rsp_cnt > v.hold) rsp_ready = 1'b1;
            end
         end
      end
      chk($sformatf("%s.idle_at", tag), idle_at, e.idle_at);
      chk($sformatf("%s.bus_cycles", tag), bus_cnt, e.bus_cycles);
      chk($sformatf("%s.rsp_cycles", tag), rsp_cnt, e.rsp ? v.hold + 1 : 0);
      chk($sformatf("%s.bus_fields", tag), bus_bad, 0);
      chk($sformatf("%s.rsp_held", tag), rsp_bad, 0);
      chk($sformatf("%s.overlap", tag), overlap, 0);
      if (e.rsp) begin
         chk($sformatf("%s.status", tag), st_seen, e.st);
         chk($sformatf("%s.data", tag), d_seen, e.data);
      end
   endtask

   rec_t tbl[9];

   initial begin
      // Hand-derived expectations with TIMEOUT=4.
      tbl[0] = '{mkv(2'b10, 16'h0010, 32'h0, 4'h0, 3, 2'b00, 32'hDEADBEEF, 0),
                 mke(1, 3, 2'b00, 32'hDEADBEEF, 5)};
      tbl[1] = '{mkv(2'b11, 16'h0020, 32'h12345678, 4'b0101, 1, 2'b10, 32'hAAAAAAAA, 0),
                 mke(1, 1, 2'b10, 32'h0, 3)};
      tbl[2] = '{mkv(2'b01, 16'h0004, 32'hCAFEF00D, 4'hF, 1, 2'b00, 32'h0, 0),
                 mke(0, 1, 2'b00, 32'h0, 2)};
      tbl[3] = '{mkv(2'b10, 16'h0030, 32'h0, 4'h0, 99, 2'b00, 32'h11111111, 0),
                 mke(1, 4, 2'b10, 32'h0, 6)};
      tbl[4] = '{mkv(2'b10, 16'h0030, 32'h0, 4'h0, 4, 2'b00, 32'h0BADF00D, 0),
                 mke(1, 4, 2'b00, 32'h0BADF00D, 6)};
      tbl[5] = '{mkv(2'b00, 16'h0044, 32'h77, 4'h3, 1, 2'b00, 32'h0, 5),
                 mke(1, 0, 2'b10, 32'h0, 7)};
      tbl[6] = '{mkv(2'b10, 16'h0048, 32'h0, 4'h0, 2, 2'b01, 32'h13572468, 1),
                 mke(1, 2, 2'b01, 32'h13572468, 5)};
      tbl[7] = '{mkv(2'b10, 16'h004C, 32'h0, 4'h0, 1, 2'b11, 32'h00000055, 0),
                 mke(1, 1, 2'b11, 32'h00000055, 3)};
      tbl[8] = '{mkv(2'b01, 16'h0050, 32'h9, 4'h1, 99, 2'b00, 32'h0, 0),
                 mke(0, 4, 2'b00, 32'h0, 5)};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_access = '0; cmd_address = '0;
      cmd_wdata = '0; cmd_strobe = '0; rsp_ready = 1'b0; bus_ready = 1'b0;
      bus_status = '0; bus_rdata = '0;

      #3;
      chk("reset.cmd_ready", cmd_ready, 1);
      chk("reset.bus_valid", bus_valid, 0);
      chk("reset.rsp_valid", rsp_valid, 0);
      chk("reset.bus_address", bus_address, 0);
      chk("reset.rsp_fields", {rsp_status, rsp_rdata}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_txn(tbl[i].v, tbl[i].e, $sformatf("dir%0d", i));

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v = mkv(2'($urandom_range(0, 3)), 16'($urandom), $urandom, 4'($urandom),
                 $urandom_range(1, 6), 2'($urandom), $urandom, $urandom_range(0, 3));
         run_txn(v, model(v), $sformatf("rnd%0d", i));
      end

      // Reset while a read waits on the bus.
      cmd_valid = 1'b1; cmd_access = 2'b10; cmd_address = 16'h0060;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("midrst.bus_valid_before", bus_valid, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.bus_valid", bus_valid, 0);
      chk("midrst.rsp_valid", rsp_valid, 0);
      chk("midrst.cmd_ready", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(mkv(2'b10, 16'h0064, 32'h0, 4'h0, 2, 2'b00, 32'h600DCAFE, 0),
              mke(1, 2, 2'b00, 32'h600DCAFE, 4), "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rggen_bus_initiator.md
Name: rggen_bus_initiator

Overview:
Initiator end of the rggen register bus. Accepts access commands from a host-side valid/ready command channel and drives one register-bus transaction at a time, with optional timeout. Returns status and read data on a valid/ready response channel, except for posted writes. Used by bridges, debug masters and sequencers that must issue register accesses.

Parameters:
ADDRESS_WIDTH, 16, width of command and bus address
BUS_WIDTH, 32, width of data and byte-granular strobe (BUS_WIDTH/8 strobe bits)
TIMEOUT, 0, cycles o_bus_valid may wait for i_bus_ready before abort; 0 disables timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid and ready
i_cmd_access  in  2  rggen_access encoding
i_cmd_address  in  ADDRESS_WIDTH  target address
i_cmd_write_data  in  BUS_WIDTH  write data
i_cmd_strobe  in  BUS_WIDTH/8  byte strobe
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed
o_rsp_status  out  2  rggen_status
o_rsp_read_data  out  BUS_WIDTH  read data, 0 for writes and errors
o_bus_valid  out  1  register-bus request valid
o_bus_access  out  2  rggen_access
o_bus_address  out  ADDRESS_WIDTH  register-bus address
o_bus_write_data  out  BUS_WIDTH  register-bus write data
o_bus_strobe  out  BUS_WIDTH/8  register-bus strobe
i_bus_ready  in  1  register-bus completion
i_bus_status  in  2  rggen_status from the register block
i_bus_read_data  in  BUS_WIDTH  read data from the register block

Behaviour:
- Reset values: all outputs 0, except o_cmd_ready=1. State IDLE, timer 0.
- FSM states: IDLE, BUS, RSP.
- IDLE: o_cmd_ready=1. On i_cmd_valid, register the command.
  - Access READ, WRITE or POSTED_WRITE: go to BUS.
  - Access 2'b00 (illegal): go to RSP with status SLAVE_ERROR and data 0. No bus transaction is issued.
- BUS: o_bus_valid=1. All o_bus_* fields are held stable until completion.
  - On i_bus_ready: capture i_bus_status unchanged. Capture i_bus_read_data only if access bit RGGEN_ACCESS_DATA_BIT=0 (read); otherwise capture 0.
  - If the access is POSTED_WRITE (RGGEN_ACCESS_NON_POSTED_BIT=0), drop the response and go to IDLE. Otherwise go to RSP.
- BUS timeout (TIMEOUT>0): the timer counts cycles in BUS with i_bus_ready low.
  - When the timer reaches TIMEOUT, deassert o_bus_valid the next cycle and go to RSP (SLAVE_ERROR, data 0). A posted write that times out also goes to IDLE silently.
  - If i_bus_ready arrives in the same cycle the timer reaches TIMEOUT, ready wins: normal completion.
  - The timer clears on every entry to BUS. Timer width is clog2(TIMEOUT+1).
- RSP: o_rsp_valid=1, status and data held. On i_rsp_ready go to IDLE. o_cmd_ready=0 throughout RSP; there is no overlap.
- Latency: command accepted at cycle T; o_bus_valid asserted in T+1; bus ready at T+k; o_rsp_valid asserted in T+k+1. With k=1, back-to-back non-posted commands are accepted at best every 3 cycles. Posted writes are accepted at best every 2 cycles.
- Reset mid-operation: asynchronous return to reset values. An in-flight bus request is abandoned immediately (o_bus_valid drops without waiting for ready).
- The bus status is forwarded transparently: OKAY, EXOKAY, SLAVE_ERROR and DECODE_ERROR are never remapped.

Decomposition:
- Shared package rggen_rtl_pkg gains:
  - enum rggen_initiator_state {IDLE, BUS, RSP}
  - function rggen_timer_width(int timeout), returning clog2(timeout+1) with a minimum of 1
- The existing rggen_access and rggen_status types and the access bit constants are reused.
- One sub-module: rggen_bus_timer (clear/enable/expire counter parameterised by TIMEOUT; constant expire=0 when TIMEOUT=0).

Test Plan:
- Read at 0x0010, ready after 3 cycles with data 0xDEADBEEF and status OKAY -> one o_rsp_valid with status 2'b00 and data 0xDEADBEEF. o_bus_* stable during the wait.
- WRITE with data 0x12345678 and strobe 4'b0101, ready with SLAVE_ERROR -> bus sees identical data and strobe; response status 2'b10, data 0.
- POSTED_WRITE to 0x0004, ready after 1 cycle -> no o_rsp_valid. o_cmd_ready returns 1 two cycles after acceptance.
- TIMEOUT=4, read with i_bus_ready held low -> o_bus_valid high exactly 4 cycles then drops; response SLAVE_ERROR, data 0. A repeat run with ready in the 4th cycle -> normal OKAY response.
- Illegal access 2'b00 -> o_bus_valid never asserts; response SLAVE_ERROR. Then hold i_rsp_ready low for 5 cycles -> response held and o_cmd_ready=0 until the response is consumed.
- Assert i_rst_n low while in BUS -> o_bus_valid=0 and o_rsp_valid=0 asynchronously, o_cmd_ready=1. A subsequent read completes normally.
